// File: rtl/tour_pkg.sv
// Shared constants and types for the tour command sequencer.
package tour_pkg;

    // Response byte that RemoteComm returns for a successful command
    localparam logic [7:0]  POS_ACK     = 8'hA5;

    // Knight command encodings {opcode[15:12], heading[11:4], squares[3:0]}
    localparam logic [15:0] CAL_GYRO    = 16'h2000;
    localparam logic [3:0]  OP_MOVE     = 4'h4;
    localparam logic [3:0]  OP_MOVE_FAN = 4'h5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_SNT = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_ERR      = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NAK     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: synchronous push/pop, simultaneous push+pop legal even when
// full, pushes while full (without a pop) are dropped, flush empties it.
module cmd_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush takes precedence over traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Plays queued Knight commands into RemoteComm one at a time, waiting for
// transmission and a positive ack before issuing the next one.
module tour_cmd_sequencer #(
    parameter int         DEPTH       = 8,
    parameter int         ACK_TIMEOUT = 50_000_000,
    parameter logic [7:0] POS_ACK     = tour_pkg::POS_ACK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_cmd,
    input  logic [15:0]             wr_data,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    start,
    input  logic                    abort,
    output logic [15:0]             cmd,
    output logic                    snd_cmd,
    input  logic                    cmd_snt,
    input  logic                    resp_rdy,
    input  logic [7:0]              resp,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [7:0]              n_done
);

    import tour_pkg::*;

    localparam int TO_W = $clog2(ACK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic [15:0]     fifo_head;
    logic            fifo_empty;
    logic            pop;
    logic            flush;
    logic            snd_d;
    logic            done_d;
    logic            clr_run;
    logic            set_err;
    logic [1:0]      code_d;
    logic            ack_ok;
    logic [TO_W-1:0] to_cnt_q;

    cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (16)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_cmd),
        .wr_data (wr_data),
        .pop     (pop),
        .flush   (flush),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT_SNT) ||
                  (state_q == S_WAIT_ACK);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and strobes; popping happens on the edge that enters ISSUE
    // so cmd and snd_cmd are both registered and valid during ISSUE
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        flush   = 1'b0;
        snd_d   = 1'b0;
        done_d  = 1'b0;
        clr_run = 1'b0;
        set_err = 1'b0;
        code_d  = ERR_NONE;
        ack_ok  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        clr_run = 1'b1;
                        if (!fifo_empty) begin
                            state_d = S_ISSUE;
                            pop     = 1'b1;
                            snd_d   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_ISSUE: state_d = S_WAIT_SNT;
                S_WAIT_SNT: begin
                    if (cmd_snt) state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (resp_rdy) begin
                        if (resp == POS_ACK) begin
                            ack_ok = 1'b1;
                            if (!fifo_empty) begin
                                state_d = S_ISSUE;
                                pop     = 1'b1;
                                snd_d   = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            state_d = S_ERR;
                            set_err = 1'b1;
                            code_d  = ERR_NAK;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = S_ERR;
                        set_err = 1'b1;
                        code_d  = ERR_TIMEOUT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Ack timeout counter: held at zero outside WAIT_ACK, saturates at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     to_cnt_q <= '0;
        else if (state_q != S_WAIT_ACK) to_cnt_q <= '0;
        else if (to_cnt_q != TO_LAST)   to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    // Registered outputs: command word, strobes, error status and ack tally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= '0;
            snd_cmd  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            n_done   <= '0;
        end else begin
            snd_cmd <= snd_d;
            done    <= done_d;
            if (pop) cmd <= fifo_head;
            if (abort || clr_run) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end else if (set_err) begin
                err      <= 1'b1;
                err_code <= code_d;
            end
            if (clr_run)                     n_done <= '0;
            else if (ack_ok && n_done != 8'hFF) n_done <= n_done + 8'd1;
        end
    end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Self-checking bench for tour_cmd_sequencer (DEPTH=8, ACK_TIMEOUT=100).
`timescale 1ns/1ps
module tb_tour_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_cmd;
    logic [15:0] wr_data;
    logic        full;
    logic [3:0]  count;
    logic        start;
    logic        abort;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  n_done;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    logic [15:0] exp_q[$];

    tour_cmd_sequencer #(
        .DEPTH       (8),
        .ACK_TIMEOUT (100),
        .POS_ACK     (8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_cmd   (wr_cmd),
        .wr_data  (wr_data),
        .full     (full),
        .count    (count),
        .start    (start),
        .abort    (abort),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .n_done   (n_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [15:0] d);
        wr_cmd  = 1'b1;
        wr_data = d;
        if (m_cnt < 8) begin
            exp_q.push_back(d);
            m_cnt++;
        end
        tick();
        wr_cmd = 1'b0;
    endtask

    task automatic model_flush();
        exp_q.delete();
        m_cnt = 0;
    endtask

    // Wait (bounded) for snd_cmd, then score the issued command word
    task automatic wait_snd(input string tag);
        logic [15:0] e;
        int i;
        i = 0;
        while (!snd_cmd && i < 20) begin
            tick();
            i++;
        end
        checks++;
        if (!snd_cmd) begin
            errors++;
            $display("FAIL %s snd_cmd timeout: got 0 want 1", tag);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected snd_cmd: cmd %h, queue empty", tag, cmd);
        end else begin
            e = exp_q.pop_front();
            m_cnt--;
            if (cmd !== e) begin
                errors++;
                $display("FAIL %s cmd: got %h want %h", tag, cmd, e);
            end
        end
    endtask

    // RemoteComm model: transmit, optionally inject a stray response, then respond
    task automatic remote_ack(input logic [7:0] r, input bit spurious, input logic [7:0] n_exp);
        tick();
        checks++;
        if (snd_cmd !== 1'b0) begin
            errors++;
            $display("FAIL snd_pulse_width: got %b want 0", snd_cmd);
        end
        if (spurious) begin
            resp = 8'hA5; resp_rdy = 1'b1;
            tick();
            resp_rdy = 1'b0;
            checks++;
            if (n_done !== n_exp || busy !== 1'b1) begin
                errors++;
                $display("FAIL spurious_wait_snt: n_done %0d busy %b want %0d 1", n_done, busy, n_exp);
            end
        end
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        tick();
        resp = r; resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd, snd_cmd, busy, done, err, err_code, n_done, full, count} !== '0) begin
            errors++;
            $display("FAIL reset_values: cmd %h snd %b busy %b done %b err %b code %0d n %0d full %b cnt %0d want all 0",
                     cmd, snd_cmd, busy, done, err, err_code, n_done, full, count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_play3();
        push_cmd(16'h2000);
        push_cmd(16'h4BF1);
        push_cmd(16'h57F2);
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL play3_count: got %0d want 3", count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_snd("play3");
            remote_ack(8'hA5, (k == 0), 8'(k));
            checks++;
            if (done !== (k == 2)) begin
                errors++;
                $display("FAIL play3_done_%0d: got %b want %b", k, done, (k == 2));
            end
            checks++;
            if (n_done !== 8'(k + 1)) begin
                errors++;
                $display("FAIL play3_n_done_%0d: got %0d want %0d", k, n_done, k + 1);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL play3_end: done %b busy %b left %0d want 0 0 0", done, busy, exp_q.size());
        end
    endtask

    task automatic test_nak();
        push_cmd(16'h4BF1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_snd("nak");
        remote_ack(8'h5A, 1'b0, 8'd0);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL nak_err: err %b code %0d busy %b done %b want 1 1 0 0", err, err_code, busy, done);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL nak_restart_empty: done %b err %b code %0d want 1 0 0", done, err, err_code);
        end
        tick();
        resp = 8'hA5; resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        tick();
        checks++;
        if (n_done !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: n_done %0d busy %b done %b want 0 0 0", n_done, busy, done);
        end
    endtask

    task automatic test_timeout();
        push_cmd(16'h4C31);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_snd("timeout");
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        repeat (99) tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err %b at 99 clks want 0", err);
        end
        tick();
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_code: err %b code %0d busy %b want 1 2 0", err, err_code, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL abort_clears_err: err %b code %0d want 0 0", err, err_code);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 9; i++) push_cmd(16'h4000 + 16'(i));
        checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL full_flags: full %b count %0d want 1 8", full, count);
        end
        wr_cmd = 1'b1; wr_data = 16'h5AB3; start = 1'b1;
        tick();
        wr_cmd = 1'b0; start = 1'b0;
        wait_snd("full_pushpop");
        exp_q.push_back(16'h5AB3);
        m_cnt++;
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop_count: count %0d full %b want 8 1", count, full);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_flush();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || snd_cmd !== 1'b0) begin
            errors++;
            $display("FAIL full_abort: count %0d busy %b snd %b want 0 0 0", count, busy, snd_cmd);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 4; i++) push_cmd(16'h2000 + 16'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_snd("abort");
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_flush();
        checks++;
        if (busy !== 1'b0 || count !== 4'd0 || done !== 1'b0 || snd_cmd !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_ack: busy %b count %0d done %b snd %b want 0 0 0 0", busy, count, done, snd_cmd);
        end
        resp = 8'hA5; resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        tick();
        checks++;
        if (n_done !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || snd_cmd !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_resp: n_done %0d busy %b done %b snd %b want 0 0 0 0", n_done, busy, done, snd_cmd);
        end
    endtask

    task automatic test_reset_mid();
        push_cmd(16'h57F2);
        push_cmd(16'h4BF1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_snd("reset_mid");
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_flush();
        checks++;
        if ({cmd, snd_cmd, busy, done, err, err_code, n_done, full, count} !== '0) begin
            errors++;
            $display("FAIL reset_mid: cmd %h snd %b busy %b done %b err %b code %0d n %0d full %b cnt %0d want all 0",
                     cmd, snd_cmd, busy, done, err, err_code, n_done, full, count);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_cmd   = 1'b0;
        wr_data  = '0;
        start    = 1'b0;
        abort    = 1'b0;
        cmd_snt  = 1'b0;
        resp_rdy = 1'b0;
        resp     = '0;
        test_reset();
        test_play3();
        test_nak();
        test_timeout();
        test_full();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
